// File: rtl/cordic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cordic_ctrl_pkg
// Shared definitions for the CORDIC Arch3 operand-mux sequencer:
//   - state_e  : sequencer state enumeration
//   - SEL_*    : select codes of the 3x1 operand mux (plus the zero input)
// No ports (package).
// -----------------------------------------------------------------------------
package cordic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ITER  = 3'd3,
    ST_SCALE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_CH0  = 2'b01;
  localparam logic [1:0] SEL_CH1  = 2'b10;
  localparam logic [1:0] SEL_CH2  = 2'b11;

endpackage

// File: rtl/cordic_mux_sequencer_if.sv
// -----------------------------------------------------------------------------
// cordic_mux_sequencer_if
// Handshake and control bus between the sequencer and its environment.
//   beg_op   : start request            (master -> slave)
//   ack_op   : result acknowledge       (master -> slave)
//   abort    : cancel current operation (master -> slave)
//   sel_mux  : operand mux select       (slave -> master)
//   load_en  : mux-output register load (slave -> master)
//   iter_idx : micro-rotation index     (slave -> master)
//   busy     : sequencer not idle       (slave -> master)
//   ready    : result valid until ack   (slave -> master)
// Modports: master (requester side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface cordic_mux_sequencer_if #(
  parameter int ITER = 16,
  parameter int CW   = $clog2(ITER)
) ();

  logic          beg_op;
  logic          ack_op;
  logic          abort;
  logic [1:0]    sel_mux;
  logic          load_en;
  logic [CW-1:0] iter_idx;
  logic          busy;
  logic          ready;

  modport master (
    output beg_op, ack_op, abort,
    input  sel_mux, load_en, iter_idx, busy, ready
  );

  modport slave (
    input  beg_op, ack_op, abort,
    output sel_mux, load_en, iter_idx, busy, ready
  );

endinterface

// File: rtl/cordic_iter_counter.sv
// -----------------------------------------------------------------------------
// cordic_iter_counter
// CW-bit micro-rotation index counter. Saturates at ITER-1 (never wraps) and
// flags the terminal count.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clr_i   : synchronous clear (wins over enable)
//   en_i    : count enable
//   idx_o   : current index
//   term_o  : idx_o == ITER-1
// -----------------------------------------------------------------------------
module cordic_iter_counter #(
  parameter int ITER = 16,
  parameter int CW   = $clog2(ITER)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] idx_o,
  output logic          term_o
);

  logic [CW-1:0] idx_q;
  logic [CW-1:0] idx_d;

  assign term_o = (idx_q == CW'(ITER - 1));
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i && !term_o) begin
      idx_d = idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/cordic_mux_sequencer.sv
// -----------------------------------------------------------------------------
// cordic_mux_sequencer
// Control FSM for the CORDIC Arch3 operand 3x1 mux. Sequences a register
// clear, the initial ch_0 load, ITER ch_1 feedback iterations and (optionally)
// one ch_2 scale-correction pass, then holds ready until acknowledged.
//
// Build option:
//   CORDIC_SCALE_EN defined   : SCALE state present, beg->ready = ITER+4 cycles
//   CORDIC_SCALE_EN undefined : ITER goes straight to DONE, beg->ready = ITER+3,
//                               sel_mux never takes the ch_2 code
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cordic_mux_sequencer_if.slave
//            in : beg_op, ack_op, abort
//            out: sel_mux, load_en, iter_idx, busy, ready
// -----------------------------------------------------------------------------
module cordic_mux_sequencer
  import cordic_ctrl_pkg::*;
#(
  parameter int ITER = 16,
  parameter int CW   = $clog2(ITER)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cordic_mux_sequencer_if.slave        bus
);

  state_e        state_q;
  logic [1:0]    sel_q;
  logic          load_q;
  logic          busy_q;
  logic          ready_q;

  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_term;
  logic [CW-1:0] cnt_idx;

  // The counter only runs in ITER. Clearing it everywhere else (and on the
  // terminal cycle / abort) keeps iter_idx at 0 outside ITER and guarantees a
  // fresh 0 on every entry to ITER.
  assign cnt_en  = (state_q == ST_ITER);
  assign cnt_clr = (state_q != ST_ITER) || cnt_term || bus.abort;

  cordic_iter_counter #(
    .ITER (ITER),
    .CW   (CW)
  ) u_iter_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .idx_o  (cnt_idx),
    .term_o (cnt_term)
  );

  // Outputs are registered alongside the state so each one is a plain flop;
  // the only combinational path is abort killing the load strobe immediately.
  // load_q is already 0 in IDLE, so abort there has no visible effect.
  assign bus.sel_mux  = sel_q;
  assign bus.load_en  = load_q & ~bus.abort;
  assign bus.iter_idx = cnt_idx;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_ZERO;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else if (bus.abort && (state_q != ST_IDLE)) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_ZERO;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.beg_op) begin
            state_q <= ST_CLEAR;
            sel_q   <= SEL_ZERO;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end

        ST_CLEAR: begin
          state_q <= ST_LOAD;
          sel_q   <= SEL_CH0;
          load_q  <= 1'b1;
        end

        ST_LOAD: begin
          state_q <= ST_ITER;
          sel_q   <= SEL_CH1;
          load_q  <= 1'b1;
        end

        ST_ITER: begin
          if (cnt_term) begin
`ifdef CORDIC_SCALE_EN
            state_q <= ST_SCALE;
            sel_q   <= SEL_CH2;
            load_q  <= 1'b1;
`else
            state_q <= ST_DONE;
            sel_q   <= SEL_ZERO;
            load_q  <= 1'b0;
            ready_q <= 1'b1;
`endif
          end
        end

`ifdef CORDIC_SCALE_EN
        ST_SCALE: begin
          state_q <= ST_DONE;
          sel_q   <= SEL_ZERO;
          load_q  <= 1'b0;
          ready_q <= 1'b1;
        end
`endif

        ST_DONE: begin
          // beg_op is deliberately not looked at here: a new operation may
          // only start after at least one cycle in IDLE.
          if (bus.ack_op) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_ZERO;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          sel_q   <= SEL_ZERO;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
